// File: rtl/larpix_piso_rx.sv
// rtl/larpix_piso_rx.sv - UART-framed PISO lane receiver with parity check and FWFT word FIFO
//
// Ports:
//   clk               master clock (same clock as the chip)
//   reset_n           asynchronous active-low reset
//   piso              serial lane from the chip, idles high, asynchronous phase
//   rx_data           head-of-FIFO word, bit 0 = first bit received
//   rx_parity_err     head word failed odd parity
//   rx_valid          head word present
//   rx_ready          consumer accepts the head word
//   fifo_count        words currently held (0..FIFO_DEPTH)
//   overflow_count    saturating count of words dropped on a full FIFO
//   framing_err_count saturating count of packets with a bad stop bit
//   clear_counts      synchronous clear of both error counters

`timescale 1ns/1ps

module larpix_piso_rx #(
    parameter int WIDTH        = 64,
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          piso,
    output logic [WIDTH-1:0]              rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]              overflow_count,
    output logic [CNT_W-1:0]              framing_err_count,
    input  logic                          clear_counts
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCW   = PTR_W + 1;

    localparam logic [TMR_W-1:0] TMR_HALF  = TMR_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [TMR_W-1:0] TMR_FULL  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [FCW-1:0]   DEPTH_CNT = FCW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic             piso_m;
    logic             piso_s;
    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic [IDX_W-1:0] bit_idx;
    logic [WIDTH-1:0] shift;
    logic             tmr_exp;

    // Synchronizer flops reset to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            piso_m <= 1'b1;
            piso_s <= 1'b1;
        end else begin
            piso_m <= piso;
            piso_s <= piso_m;
        end
    end

    assign tmr_exp = (timer == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!piso_s) begin
                        state <= S_START;
                        timer <= TMR_HALF;
                    end
                end
                S_START: begin
                    if (tmr_exp) begin
                        if (!piso_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                            timer   <= TMR_FULL;
                        end else begin
                            // Start bit vanished by mid-bit: a glitch, silently ignored.
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (tmr_exp) begin
                        shift[bit_idx] <= piso_s;
                        timer          <= TMR_FULL;
                        if (bit_idx == IDX_LAST) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_STOP: begin
                    if (tmr_exp) begin
                        state <= piso_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (piso_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic stop_sample;
    logic push;
    logic frame_err;
    logic pop;
    logic push_ok;
    logic drop;

    assign stop_sample = (state == S_STOP) && tmr_exp;
    assign push        = stop_sample &  piso_s;
    assign frame_err   = stop_sample & ~piso_s;

    assign rx_valid = (fifo_count != '0);
    assign pop      = rx_valid & rx_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = push & ((fifo_count != DEPTH_CNT) | pop);
    assign drop     = push & ~push_ok;

    logic [WIDTH:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH:0]   head;

    // Storage is not reset; the head outputs are gated by rx_valid instead.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {~(^shift), shift};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + FCW'(1);
                2'b01:   fifo_count <= fifo_count - FCW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign head          = mem[rd_ptr];
    assign rx_data       = rx_valid ? head[WIDTH-1:0] : '0;
    assign rx_parity_err = rx_valid & head[WIDTH];

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_count    <= '0;
            framing_err_count <= '0;
        end else if (clear_counts) begin
            overflow_count    <= '0;
            framing_err_count <= '0;
        end else begin
            if (drop && overflow_count != CNT_MAX) begin
                overflow_count <= overflow_count + CNT_W'(1);
            end
            if (frame_err && framing_err_count != CNT_MAX) begin
                framing_err_count <= framing_err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_larpix_piso_rx.sv
// tb/tb_larpix_piso_rx.sv - self-checking bench for larpix_piso_rx

`timescale 1ns/1ps

module tb_larpix_piso_rx;

    localparam int WIDTH = 64;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              piso;
    logic [WIDTH-1:0]  rx_data;
    logic              rx_parity_err;
    logic              rx_valid;
    logic              rx_ready;
    logic [4:0]        fifo_count;
    logic [CNT_W-1:0]  overflow_count;
    logic [CNT_W-1:0]  framing_err_count;
    logic              clear_counts;

    larpix_piso_rx #(
        .WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .piso(piso),
        .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .fifo_count(fifo_count),
        .overflow_count(overflow_count), .framing_err_count(framing_err_count),
        .clear_counts(clear_counts)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             perr;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t             exp_q[$];
    logic [CNT_W-1:0] exp_ovf;
    logic [CNT_W-1:0] exp_frm;
    int               checks = 0;
    int               errors = 0;

    function automatic logic even_ones(input logic [WIDTH-1:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // Receiver model: a good packet lands in the FIFO if there is room, otherwise it is dropped.
    task automatic model_push(input logic [WIDTH-1:0] w);
        ent_t e;
        e.perr = even_ones(w);
        e.data = w;
        if (exp_q.size() < DEPTH) exp_q.push_back(e);
        else exp_ovf = exp_ovf + 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        piso = b;
        tick(CPB);
    endtask

    task automatic send_packet(input logic [WIDTH-1:0] w, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
        drive_bit(stop_bit);
    endtask

    task automatic drain(input string name);
        ent_t e;
        int   budget;
        rx_ready = 1'b1;
        budget   = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            if (rx_valid) begin
                e = exp_q.pop_front();
                checks++;
                if (rx_data !== e.data || rx_parity_err !== e.perr) begin
                    errors++;
                    $display("FAIL %s_word: got data=%h perr=%b expected data=%h perr=%b",
                             name, rx_data, rx_parity_err, e.data, e.perr);
                end
            end
            tick(1);
            budget++;
        end
        rx_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d words still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL %s_empty: fifo_count=%0d expected 0", name, fifo_count);
        end
    endtask

    task automatic check_counters(input string name);
        checks++;
        if (overflow_count !== exp_ovf || framing_err_count !== exp_frm) begin
            errors++;
            $display("FAIL %s_counters: got ovf=%0d frm=%0d expected ovf=%0d frm=%0d",
                     name, overflow_count, framing_err_count, exp_ovf, exp_frm);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (rx_valid !== 1'b0 || rx_data !== '0 || rx_parity_err !== 1'b0 ||
            fifo_count !== 5'd0 || overflow_count !== '0 || framing_err_count !== '0) begin
            errors++;
            $display("FAIL %s_outputs: got valid=%b data=%h perr=%b cnt=%0d ovf=%0d frm=%0d expected all 0",
                     name, rx_valid, rx_data, rx_parity_err, fifo_count, overflow_count, framing_err_count);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; piso = 1'b1; rx_ready = 1'b0; clear_counts = 1'b0;
        exp_ovf = '0; exp_frm = '0;
        tick(3);
        check_all_zero("reset_held");
        reset_n = 1'b1;
        tick(5);
        check_all_zero("reset_released");
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] w;
        w = 64'h0123_4567_89AB_CDEE;
        drive_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
        piso = 1'b1;
        // Line to rx_valid: two sync flops, half a bit to the mid-stop sample, one register stage.
        tick(2 + CPB/2);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: rx_valid=%b expected 0", rx_valid);
        end
        tick(1);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== w || rx_parity_err !== 1'b0) begin
            errors++;
            $display("FAIL single_word: got valid=%b data=%h perr=%b expected valid=1 data=%h perr=0",
                     rx_valid, rx_data, rx_parity_err, w);
        end
        tick(CPB);
        model_push(w);
        drain("single");
    endtask

    task automatic test_parity();
        logic [WIDTH-1:0] w;
        w = 64'h0000_0000_0000_0003;
        send_packet(w, 1'b1);
        model_push(w);
        tick(4);
        checks++;
        if (rx_valid !== 1'b1 || rx_parity_err !== 1'b1 || rx_data !== w) begin
            errors++;
            $display("FAIL parity_head: got valid=%b perr=%b data=%h expected valid=1 perr=1 data=%h",
                     rx_valid, rx_parity_err, rx_data, w);
        end
        check_counters("parity");
        drain("parity");
    endtask

    task automatic test_random_burst();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < 6; i++) begin
            w = rand_word();
            if (i == 2) w = {w[WIDTH-1:1], ~(^w[WIDTH-1:1])};
            send_packet(w, 1'b1);
            model_push(w);
        end
        tick(4);
        checks++;
        if (fifo_count !== 5'(exp_q.size())) begin
            errors++;
            $display("FAIL burst_count: fifo_count=%0d expected %0d", fifo_count, exp_q.size());
        end
        drain("burst");
    endtask

    task automatic test_glitch();
        piso = 1'b0;
        tick(1);
        piso = 1'b1;
        tick(20);
        checks++;
        if (rx_valid !== 1'b0 || fifo_count !== 5'd0) begin
            errors++;
            $display("FAIL glitch_word: valid=%b count=%0d expected 0 0", rx_valid, fifo_count);
        end
        check_counters("glitch");
    endtask

    task automatic test_framing();
        logic [WIDTH-1:0] w;
        w = rand_word();
        send_packet(w, 1'b0);
        piso = 1'b1;
        exp_frm = exp_frm + 1'b1;
        tick(4);
        check_counters("framing");
        checks++;
        if (fifo_count !== 5'd0 || rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL framing_fifo: count=%0d valid=%b expected 0 0", fifo_count, rx_valid);
        end
        tick(3);
        w = rand_word();
        send_packet(w, 1'b1);
        model_push(w);
        tick(4);
        drain("framing_next");
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] w;
        rx_ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            w = rand_word();
            send_packet(w, 1'b1);
            model_push(w);
        end
        tick(4);
        checks++;
        if (fifo_count !== 5'(DEPTH)) begin
            errors++;
            $display("FAIL overflow_count_full: fifo_count=%0d expected %0d", fifo_count, DEPTH);
        end
        check_counters("overflow");
        drain("overflow");
    endtask

    task automatic test_reset_mid_packet();
        logic [WIDTH-1:0] w;
        w = rand_word();
        send_packet(w, 1'b1);
        model_push(w);
        tick(4);
        w = rand_word();
        drive_bit(1'b0);
        for (int i = 0; i < 30; i++) drive_bit(w[i]);
        piso = w[30];
        tick(2);
        reset_n = 1'b0;
        piso = 1'b0;
        tick(1);
        check_all_zero("reset_mid");
        exp_q.delete();
        exp_ovf = '0;
        exp_frm = '0;
        tick(3);
        // Line still low at release begins a fresh packet.
        reset_n = 1'b1;
        w = rand_word();
        send_packet(w, 1'b1);
        model_push(w);
        tick(4);
        check_counters("reset_after");
        drain("reset_next");
    endtask

    task automatic test_clear();
        logic [WIDTH-1:0] w;
        w = rand_word();
        send_packet(w, 1'b0);
        piso = 1'b1;
        exp_frm = exp_frm + 1'b1;
        tick(4);
        check_counters("clear_before");
        clear_counts = 1'b1;
        tick(1);
        clear_counts = 1'b0;
        exp_ovf = '0;
        exp_frm = '0;
        check_counters("clear_after");
    endtask

    // Stall stability and occupancy bound.
    logic             prev_stall = 1'b0;
    logic [WIDTH:0]   prev_head  = '0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall && rx_valid && ({rx_parity_err, rx_data} !== prev_head)) begin
                errors++;
                $display("FAIL stall_stable: head=%h expected %h", {rx_parity_err, rx_data}, prev_head);
            end
            if (fifo_count > 5'(DEPTH)) begin
                errors++;
                $display("FAIL count_bound: fifo_count=%0d exceeds %0d", fifo_count, DEPTH);
            end
        end
        prev_stall = reset_n && rx_valid && !rx_ready;
        prev_head  = {rx_parity_err, rx_data};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_random_burst();
        test_glitch();
        test_framing();
        test_overflow();
        test_reset_mid_packet();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/larpix_piso_rx.md
Name: larpix_piso_rx

Overview:
- Receiver that consumes one PISO lane of the full-chip model.
- Deserializes the UART-framed 64-bit packets on that lane, checks odd parity, and buffers completed words in a FIFO.
- Presents words to the bench scoreboard or an FPGA-side consumer over a valid/ready handshake.
- Instantiated once per lane (4 per chip) directly downstream of the chip's piso outputs.

Parameters:
- WIDTH, 64, packet width in bits, excluding start and stop bits.
- CLKS_PER_BIT, 4, clk cycles per UART bit; even, >= 4.
- FIFO_DEPTH, 16, receive FIFO depth in words; power of 2.
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  input  1  master clock, same clock that drives the chip.
- reset_n  input  1  asynchronous digital reset (active low).
- piso  input  1  serial line from one chip PISO output; idles high; asynchronous to clk phase.
- rx_data  output  WIDTH  head-of-FIFO packet word; bit 0 is the first bit received.
- rx_parity_err  output  1  head word failed odd parity.
- rx_valid  output  1  head word present.
- rx_ready  input  1  consumer accepts the head word.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held.
- overflow_count  output  CNT_W  words dropped because the FIFO was full.
- framing_err_count  output  CNT_W  packets with a bad stop bit.
- clear_counts  input  1  synchronous clear of both error counters.

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: all outputs are 0. The FIFO is empty and the FSM is in IDLE.
- Input sync: piso passes through a 2-flop synchronizer (piso_s). All decisions below use piso_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE -> START: taken on piso_s == 0. A bit timer is loaded with CLKS_PER_BIT/2 - 1.
- START: when the timer expires (mid start bit):
  - piso_s == 0 -> DATA, bit index = 0, timer = CLKS_PER_BIT - 1.
  - piso_s == 1 -> IDLE. This is a glitch: nothing is counted.
- DATA: on each timer expiry, shift piso_s into shift[bit index], LSB first, then reload the timer. After bit WIDTH-1 -> STOP.
- STOP: on timer expiry:
  - piso_s == 1 -> push the word -> IDLE.
  - piso_s == 0 -> framing_err_count++, word discarded -> WAIT_IDLE.
- WAIT_IDLE: -> IDLE on the first cycle with piso_s == 1.
- Back-to-back packets: a start bit immediately after a stop bit is accepted. IDLE re-arms in the cycle after the stop sample.
- Parity: parity_err = ~(^word), i.e. odd parity over all WIDTH bits. It is stored alongside the word in the FIFO.
- Push latency: the word appears on rx_data with rx_valid = 1 on the cycle after the stop-bit sample, when the FIFO was empty. This is registered head-of-FIFO output (FWFT style).
- Handshake:
  - Pop on rx_valid & rx_ready.
  - rx_data is stable while rx_valid = 1 and rx_ready = 0.
  - rx_ready while empty has no effect.
- Full:
  - A push accepts when fifo_count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the word is dropped and overflow_count++.
- Empty: a simultaneous push and pop on an empty FIFO is impossible because rx_valid = 0. The push wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is exact, 0..FIFO_DEPTH.
- Counters: saturate at 2^CNT_W - 1.
- clear_counts zeroes both counters next cycle. If clear_counts coincides with an increment, the counter becomes 0.
- Reset mid-packet: aborts the packet immediately. After release, a line that is still low goes to START and, if still low at mid-bit, proceeds as a new packet. Integrators hold chip and receiver reset together.
- Assertions (bench):
  - rx_data and rx_parity_err are stable under stall.
  - fifo_count never exceeds FIFO_DEPTH.
  - Bit index never exceeds WIDTH.

Test Plan:
- Single packet: send word 64'h0123_4567_89AB_CDEE (odd parity) at CLKS_PER_BIT = 4. Expect rx_valid 1 cycle after the stop sample, rx_data equal to the word, rx_parity_err = 0.
- Bad parity: send 64'h0000_0000_0000_0003 (even). Expect rx_parity_err = 1, data intact, no counter change.
- Framing: drive 0 during the stop bit. Expect framing_err_count = 1, FIFO unchanged. The next valid packet sent after line-high is received correctly.
- Glitch: a 1-cycle low pulse on piso while idle. Expect no word and both counters 0.
- Overflow: rx_ready = 0, send FIFO_DEPTH + 3 = 19 back-to-back packets. Expect fifo_count = 16 and overflow_count = 3. Draining with rx_ready = 1 returns the first 16 words in order.
- Reset mid-packet: assert reset_n = 0 at data bit 30, then release. Expect all outputs 0 and fifo_count = 0. The next full packet is received intact. Then pulse clear_counts and expect both counters 0.
